keycode_sender: RTL and testbench

//  Transmit side of the keypad-lock interface. On a start request, drives a stored
//  NUM_DIGITS-digit code onto the 4-bit key bus, one digit per clock.

---
 rtl/keylock_pkg.sv | 17 +
 rtl/keycode_shreg.sv | 48 ++++
 rtl/keycode_sender.sv | 191 +++++++++++++++++++
 tb/tb_keycode_sender.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/keylock_pkg.sv
// Shared types and constants for the keypad-lock sender and its shift register.
package keylock_pkg;

  localparam int unsigned DIGIT_W   = 4;
  localparam logic [3:0]  KEY_IDLE  = 4'hF;
  localparam int unsigned DIGIT_MAX = 9;
  localparam logic [23:0] DEFAULT_CODE = 24'h335256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_CHECK,
    ST_DONE,
    ST_GAP
  } state_e;

endpackage

// File: rtl/keycode_shreg.sv
// Holds the not-yet-sent digits of a code; presents the next digit and flags the last send cycle.
module keycode_shreg
  import keylock_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                load,
  input  logic                                shift,
  input  logic [DIGIT_W*(NUM_DIGITS-1)-1:0]   tail,
  output logic [DIGIT_W-1:0]                  digit_c,
  output logic                                last_c
);

  localparam int unsigned TAIL_W = DIGIT_W * (NUM_DIGITS - 1);
  localparam int unsigned CNT_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [TAIL_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // The first digit leaves via the top module, so only digits 1..N-1 are stored here.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (load) begin
      data_d = tail;
      cnt_d  = '0;
    end else if (shift) begin
      data_d = data_q << DIGIT_W;
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign digit_c = data_q[TAIL_W-1 -: DIGIT_W];
  assign last_c  = (cnt_q == CNT_W'(NUM_DIGITS - 1));

endmodule

// File: rtl/keycode_sender.sv
// Sends a stored keypad code to the lock one digit per clock, then reports whether it opened.
// Optional retry on timeout is enabled by defining KEYCODE_SENDER_RETRY_EN.
module keycode_sender
  import keylock_pkg::*;
#(
  parameter int unsigned        NUM_DIGITS   = 6,
  parameter int unsigned        CHECK_CYCLES = 4,
  parameter logic [DIGIT_W-1:0] IDLE_KEY     = KEY_IDLE
`ifdef KEYCODE_SENDER_RETRY_EN
  ,
  parameter int unsigned        MAX_RETRY    = 2
`endif
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] code,
  input  logic                          locked,
  output logic [DIGIT_W-1:0]            key,
  output logic                          key_valid,
  output logic                          busy,
  output logic                          done,
  output logic                          success,
  output logic                          bad_digit
`ifdef KEYCODE_SENDER_RETRY_EN
  ,
  output logic [1:0]                    retry_cnt
`endif
);

  localparam int unsigned CODE_W = DIGIT_W * NUM_DIGITS;
  localparam int unsigned TAIL_W = CODE_W - DIGIT_W;
  localparam int unsigned CHK_W  = (CHECK_CYCLES > 1) ? $clog2(CHECK_CYCLES) : 1;

  state_e               state_q, state_d;
  logic [CHK_W-1:0]     chk_cnt_q, chk_cnt_d;
  logic [DIGIT_W-1:0]   key_q, key_d;
  logic                 key_valid_q, key_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 success_q, success_d;
  logic                 bad_digit_q, bad_digit_d;
`ifdef KEYCODE_SENDER_RETRY_EN
  logic [CODE_W-1:0]    code_q, code_d;
  logic [1:0]           retry_q, retry_d;
`endif

  logic                 code_bad_c;
  logic                 sr_load, sr_shift;
  logic [TAIL_W-1:0]    sr_tail;
  logic [DIGIT_W-1:0]   first_digit;
  logic [DIGIT_W-1:0]   sr_digit_c;
  logic                 sr_last_c;

  keycode_shreg #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_shreg (
    .clk     (clk),
    .reset   (reset),
    .load    (sr_load),
    .shift   (sr_shift),
    .tail    (sr_tail),
    .digit_c (sr_digit_c),
    .last_c  (sr_last_c)
  );

  always_comb begin
    code_bad_c = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (code[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(DIGIT_MAX)) code_bad_c = 1'b1;
    end
  end

  // Next state, status flags and registered output values.
  always_comb begin
    state_d     = state_q;
    chk_cnt_d   = chk_cnt_q;
    success_d   = success_q;
    bad_digit_d = bad_digit_q;
    sr_load     = 1'b0;
    sr_shift    = 1'b0;
    sr_tail     = code[TAIL_W-1:0];
    first_digit = code[CODE_W-1 -: DIGIT_W];
`ifdef KEYCODE_SENDER_RETRY_EN
    code_d      = code_q;
    retry_d     = retry_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          success_d   = 1'b0;
          bad_digit_d = code_bad_c;
`ifdef KEYCODE_SENDER_RETRY_EN
          code_d      = code;
          retry_d     = 2'd0;
`endif
          if (code_bad_c) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SEND;
            sr_load = 1'b1;
          end
        end
      end
      ST_SEND: begin
        sr_shift = 1'b1;
        if (sr_last_c) begin
          state_d   = ST_CHECK;
          chk_cnt_d = '0;
        end
      end
      ST_CHECK: begin
        if (!locked) begin
          success_d = 1'b1;
          state_d   = ST_DONE;
        end else if (chk_cnt_q == CHK_W'(CHECK_CYCLES - 1)) begin
`ifdef KEYCODE_SENDER_RETRY_EN
          if (retry_q < 2'(MAX_RETRY)) begin
            state_d = ST_GAP;
            retry_d = retry_q + 2'd1;
          end else begin
            state_d = ST_DONE;
          end
`else
          state_d = ST_DONE;
`endif
        end else begin
          chk_cnt_d = chk_cnt_q + CHK_W'(1);
        end
      end
`ifdef KEYCODE_SENDER_RETRY_EN
      ST_GAP: begin
        state_d     = ST_SEND;
        sr_load     = 1'b1;
        sr_tail     = code_q[TAIL_W-1:0];
        first_digit = code_q[CODE_W-1 -: DIGIT_W];
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs lead the state by one edge so they line up with the state they describe.
    key_valid_d = (state_d == ST_SEND);
    key_d       = key_valid_d ? (sr_load ? first_digit : sr_digit_c) : IDLE_KEY;
    busy_d      = (state_d == ST_SEND) || (state_d == ST_CHECK) || (state_d == ST_GAP);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      chk_cnt_q   <= '0;
      key_q       <= IDLE_KEY;
      key_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      success_q   <= 1'b0;
      bad_digit_q <= 1'b0;
`ifdef KEYCODE_SENDER_RETRY_EN
      code_q      <= '0;
      retry_q     <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      chk_cnt_q   <= chk_cnt_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      success_q   <= success_d;
      bad_digit_q <= bad_digit_d;
`ifdef KEYCODE_SENDER_RETRY_EN
      code_q      <= code_d;
      retry_q     <= retry_d;
`endif
    end
  end

  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign success   = success_q;
  assign bad_digit = bad_digit_q;
`ifdef KEYCODE_SENDER_RETRY_EN
  assign retry_cnt = retry_q;
`endif

endmodule

// File: tb/tb_keycode_sender.sv
// Directed bench: keycode_sender paired with a behavioural keypad lock that opens on 335256.
module tb_keycode_sender;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [23:0] code;
  logic        locked;
  logic [3:0]  key;
  logic        key_valid, busy, done, success, bad_digit;
`ifdef KEYCODE_SENDER_RETRY_EN
  logic [1:0]  retry_cnt;
`endif

  keycode_sender dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .code      (code),
    .locked    (locked),
    .key       (key),
    .key_valid (key_valid),
    .busy      (busy),
    .done      (done),
    .success   (success),
    .bad_digit (bad_digit)
`ifdef KEYCODE_SENDER_RETRY_EN
    ,
    .retry_cnt (retry_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Lock model: opens once the last six entered digits spell 335256, relocks on any new digit.
  logic [23:0] hist;
  always @(posedge clk) begin
    if (reset) begin
      hist   <= '0;
      locked <= 1'b1;
    end else if (key_valid) begin
      hist   <= {hist[19:0], key};
      locked <= ({hist[19:0], key} != 24'h335256);
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0] keys[$];
  int         key_cyc[$];
  int         done_n, done_cyc;
  logic       done_succ, done_bad, done_busy;

  always @(negedge clk) begin
    if (key_valid) begin
      keys.push_back(key);
      key_cyc.push_back(cyc);
    end
    if (done) begin
      done_n    = done_n + 1;
      done_cyc  = cyc;
      done_succ = success;
      done_bad  = bad_digit;
      done_busy = busy;
    end
  end

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int t0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_log();
    keys.delete();
    key_cyc.delete();
    done_n = 0;
    done_cyc = -1;
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 80 && done_n < n; i++) tick();
    chk("done_seen", 32'(done_n >= n), 32'd1);
  endtask

  task automatic check_digits(input string tag, input logic [23:0] exp_code, input int base);
    chk({tag, "_nkeys"}, 32'(keys.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk({tag, "_digit"}, 32'(keys[base+i]), 32'(4'(exp_code >> (20 - 4*i))));
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    code  = 24'h0;
    clear_log();
    tick(); tick(); tick();
    chk("rst_key", 32'(key), 32'hF);
    chk("rst_key_valid", 32'(key_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_success", 32'(success), 32'd0);
    chk("rst_bad", 32'(bad_digit), 32'd0);
    reset = 1'b0;
    tick();

    // 1: correct code opens the lock
    clear_log();
    code = 24'h335256; start = 1'b1; t0 = cyc;
    tick();
    start = 1'b0;
    chk("t1_busy", 32'(busy), 32'd1);
    wait_done(1);
    check_digits("t1", 24'h335256, 0);
    chk("t1_first_cyc", 32'(key_cyc[0]), 32'(t0 + 1));
    chk("t1_last_cyc", 32'(key_cyc[5]), 32'(t0 + 6));
    chk("t1_done_cyc", 32'(done_cyc), 32'(t0 + 8));
    chk("t1_success", 32'(done_succ), 32'd1);
    chk("t1_bad", 32'(done_bad), 32'd0);
    chk("t1_busy_at_done", 32'(done_busy), 32'd0);
    tick(); tick();
    chk("t1_done_pulse", 32'(done_n), 32'd1);
    chk("t1_success_held", 32'(success), 32'd1);
    chk("t1_key_idle", 32'(key), 32'hF);

    // 2 / 6: wrong code, lock stays shut
    clear_log();
    code = 24'h335257; start = 1'b1; t0 = cyc;
    tick();
    start = 1'b0;
    chk("t2_success_cleared", 32'(success), 32'd0);
    wait_done(1);
`ifdef KEYCODE_SENDER_RETRY_EN
    chk("t6_nkeys", 32'(keys.size()), 32'd18);
    chk("t6_burst2_cyc", 32'(key_cyc[6]), 32'(t0 + 12));
    chk("t6_burst3_cyc", 32'(key_cyc[12]), 32'(t0 + 23));
    chk("t6_burst3_last", 32'(keys[17]), 32'h7);
    chk("t6_done_cyc", 32'(done_cyc), 32'(t0 + 33));
    chk("t6_retry_cnt", 32'(retry_cnt), 32'd2);
`else
    check_digits("t2", 24'h335257, 0);
    chk("t2_done_cyc", 32'(done_cyc), 32'(t0 + 11));
`endif
    chk("t2_success", 32'(done_succ), 32'd0);
    chk("t2_bad", 32'(done_bad), 32'd0);
    tick(); tick();
    chk("t2_done_pulse", 32'(done_n), 32'd1);

    // 3: non-decimal digit aborts without driving the bus
    clear_log();
    code = 24'h33A256; start = 1'b1; t0 = cyc;
    tick();
    start = 1'b0;
    wait_done(1);
    tick();
    chk("t3_nkeys", 32'(keys.size()), 32'd0);
    chk("t3_done_cyc", 32'(done_cyc), 32'(t0 + 1));
    chk("t3_bad", 32'(done_bad), 32'd1);
    chk("t3_success", 32'(done_succ), 32'd0);
    chk("t3_bad_held", 32'(bad_digit), 32'd1);
`ifdef KEYCODE_SENDER_RETRY_EN
    chk("t3_retry_cleared", 32'(retry_cnt), 32'd0);
`endif

    // 4: start re-asserted and code changed during SEND are ignored
    clear_log();
    code = 24'h335256; start = 1'b1; t0 = cyc;
    tick();
    start = 1'b0;
    code = 24'h000000;
    tick();
    start = 1'b1;
    tick(); tick();
    start = 1'b0;
    wait_done(1);
    for (int i = 0; i < 12; i++) tick();
    check_digits("t4", 24'h335256, 0);
    chk("t4_done_pulse", 32'(done_n), 32'd1);
    chk("t4_success", 32'(done_succ), 32'd1);
    chk("t4_bad_cleared", 32'(done_bad), 32'd0);

    // 5: reset on the third SEND cycle
    clear_log();
    code = 24'h335256; start = 1'b1; t0 = cyc;
    tick();
    start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_key_idle", 32'(key), 32'hF);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_key_valid", 32'(key_valid), 32'd0);
    for (int i = 0; i < 12; i++) tick();
    chk("t5_no_done", 32'(done_n), 32'd0);
    chk("t5_partial_keys", 32'(keys.size()), 32'd3);
    clear_log();
    code = 24'h335256; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1);
    chk("t5_fresh_success", 32'(done_succ), 32'd1);
    tick(); tick();

    // Back-to-back with start held; second run begins with the lock already open
    clear_log();
    chk("b2b_pre_open", 32'(locked), 32'd0);
    code = 24'h335256; start = 1'b1; t0 = cyc;
    for (int i = 0; i < 12; i++) tick();
    start = 1'b0;
    wait_done(2);
    chk("b2b_nkeys", 32'(keys.size()), 32'd12);
    chk("b2b_second_cyc", 32'(key_cyc[6]), 32'(t0 + 10));
    chk("b2b_second_digit", 32'(keys[6]), 32'h3);
    chk("b2b_done_cyc", 32'(done_cyc), 32'(t0 + 17));
    chk("b2b_success", 32'(done_succ), 32'd1);
    for (int i = 0; i < 12; i++) tick();
    chk("b2b_done_count", 32'(done_n), 32'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
